// File: rtl/noc_pkg.sv
// Shared definitions for the packet injector: FSM state encoding and header layout.
package noc_pkg;

  typedef enum logic [1:0] {IDLE, BODY, TAIL} inj_state_t;

  localparam int DES_LSB = 0;
  localparam int SRC_LSB = 4;
  localparam int LEN_LSB = 8;

  // Lower 16 bits of the header flit; the caller zero-extends to the channel width.
  function automatic logic [15:0] make_header(input logic [3:0] des,
                                              input logic [3:0] src,
                                              input logic [7:0] len);
    logic [15:0] hdr;
    hdr = '0;
    hdr[DES_LSB +: 4] = des;
    hdr[SRC_LSB +: 4] = src;
    hdr[LEN_LSB +: 8] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter that resets to, and saturates at, MAX_COUNT.
module credit_counter #(
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= WIDTH'(MAX_COUNT);
    end else if (dec && !inc) begin
      count <= count - WIDTH'(1);
    end else if (inc && !dec && (count != WIDTH'(MAX_COUNT))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/packet_injector.sv
// Builds header + payload packets from PE send commands and drives them over Req/Ack.
// Optional flow control: define INJECTOR_CREDIT_EN to gate M_Req on router credits.
module packet_injector
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PACKET_LEN = 8,
  parameter int NET_ADDR       = 4,
  parameter int ADDRX          = 0,
  parameter int ADDRY          = 0,
  parameter int CREDIT_INIT    = 4
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic [NET_ADDR-1:0]   Cmd_Des_Addr,
  input  logic [7:0]            Cmd_Len,
  input  logic                  Tx_Valid,
  output logic                  Tx_Ready,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Len_Err,
  output logic                  M_Req,
  input  logic                  M_Ack,
  output logic [DATA_WIDTH-1:0] M_Data,
  input  logic                  M_Credit
);

  localparam logic [3:0] SRC_ADDR = {2'(ADDRY), 2'(ADDRX)};
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PACKET_LEN);

  inj_state_t            state;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] flit;
  logic [7:0]            rem;
  logic                  len_err;
  logic                  m_req;
  logic                  xfer;
  logic                  credit_ok;
  logic                  tx_ready;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] header;

  assign header = DATA_WIDTH'(make_header(4'(Cmd_Des_Addr), SRC_ADDR, Cmd_Len));

`ifdef INJECTOR_CREDIT_EN
  localparam int CW = $clog2(CREDIT_INIT + 1);
  logic [CW-1:0] credits;

  credit_counter #(.MAX_COUNT(CREDIT_INIT), .WIDTH(CW)) u_credit (
    .clk   (Clock),
    .rst_n (nReset),
    .dec   (xfer),
    .inc   (M_Credit),
    .count (credits)
  );

  assign m_req     = out_valid && (credits != '0);
  assign credit_ok = (credits > CW'(1)) || !out_valid || M_Ack;
`else
  localparam int CREDIT_INIT_UNUSED = CREDIT_INIT;
  logic credit_unused;
  assign credit_unused = M_Credit;
  assign m_req         = out_valid;
  assign credit_ok     = 1'b1;
`endif

  // An Ack is only meaningful while a flit is actually being offered.
  assign xfer     = m_req && M_Ack;
  assign tx_ready = (state == BODY) && (!out_valid || xfer) && credit_ok;
  assign tx_load  = Tx_Valid && tx_ready;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      flit      <= '0;
      rem       <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (Cmd_Valid) begin
            if (Cmd_Len > MAX_LEN) begin
              len_err <= 1'b1;
            end else begin
              flit      <= header;
              out_valid <= 1'b1;
              rem       <= Cmd_Len;
              state     <= (Cmd_Len != 8'd0) ? BODY : TAIL;
            end
          end
        end
        BODY: begin
          if (tx_load) begin
            flit      <= Tx_Data;
            out_valid <= 1'b1;
            rem       <= rem - 8'd1;
            if (rem == 8'd1) state <= TAIL;
          end else if (xfer) begin
            out_valid <= 1'b0;
          end
        end
        TAIL: begin
          if (xfer) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Cmd_Ready = (state == IDLE);
  assign Tx_Ready  = tx_ready;
  assign Len_Err   = len_err;
  assign M_Req     = m_req;
  assign M_Data    = flit;

endmodule
